// File: rtl/i2c_frame_tx.sv
// Frame packer/sequencer: serialises {6'b111111, opcode, A, B, ANS} MSB-first as 13 bytes
// into a byte-level I2C master and resends the whole frame after a NACK, up to RETRY_MAX times.
module i2c_frame_tx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h07,
  parameter int         RETRY_MAX  = 3,
  parameter int         GAP_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_ans,
  output logic        m_start,
  output logic [6:0]  m_addr,
  output logic        m_byte_valid,
  output logic [7:0]  m_byte,
  output logic        m_byte_last,
  input  logic        m_byte_ready,
  input  logic        m_done,
  input  logic        m_nack,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  retry_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    SEND      = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4,
    GAP       = 3'd5,
    ERR       = 3'd6
  } state_t;

  localparam logic [3:0]  LAST_IDX  = 4'd12;
  localparam logic [1:0]  RETRY_LIM = 2'(RETRY_MAX);
  localparam logic [15:0] GAP_END   = 16'(GAP_CYCLES - 1);

  state_t        state_r, state_s, fail_state_s;
  logic [103:0]  frame_r, frame_s;
  logic [3:0]    idx_r, idx_s;
  logic [1:0]    retry_r, retry_s, fail_retry_s;
  logic [15:0]   gap_r, gap_s;

  logic          req_ready_r, m_start_r, m_byte_valid_r, m_byte_last_r;
  logic          busy_r, frame_done_r, frame_err_r;
  logic [7:0]    m_byte_r;

  // Byte idx of the frame, counted from the MSB end.
  function automatic logic [7:0] frame_byte(input logic [103:0] frame, input logic [3:0] idx);
    return 8'(frame >> (7'd96 - {idx, 3'b000}));
  endfunction

  // Next-state logic; a NACK or a premature m_done both take the fail path.
  always_comb begin
    state_s = state_r;
    frame_s = frame_r;
    idx_s   = idx_r;
    retry_s = retry_r;
    gap_s   = gap_r;
    if (retry_r < RETRY_LIM) begin
      fail_state_s = GAP;
      fail_retry_s = retry_r + 2'd1;
    end else begin
      fail_state_s = ERR;
      fail_retry_s = retry_r;
    end
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          frame_s = {6'b111111, req_opcode, req_a, req_b, req_ans};
          idx_s   = 4'd0;
          retry_s = 2'd0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        idx_s   = 4'd0;
        state_s = SEND;
      end
      SEND: begin
        if (m_done) begin
          state_s = fail_state_s;
          retry_s = fail_retry_s;
          idx_s   = 4'd0;
          gap_s   = 16'd0;
        end else if (m_byte_ready) begin
          if (idx_r == LAST_IDX) begin
            state_s = WAIT_DONE;
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end else begin
          state_s = SEND;
        end
      end
      WAIT_DONE: begin
        if (m_done && m_nack) begin
          state_s = fail_state_s;
          retry_s = fail_retry_s;
          idx_s   = 4'd0;
          gap_s   = 16'd0;
        end else if (m_done) begin
          state_s = DONE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      GAP: begin
        if (gap_r == GAP_END) begin
          state_s = START;
        end else begin
          gap_s = gap_r + 16'd1;
        end
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      frame_r <= 104'd0;
      idx_r   <= 4'd0;
      retry_r <= 2'd0;
      gap_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      frame_r <= frame_s;
      idx_r   <= idx_s;
      retry_r <= retry_s;
      gap_r   <= gap_s;
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r    <= 1'b1;
      m_start_r      <= 1'b0;
      m_byte_valid_r <= 1'b0;
      m_byte_r       <= 8'h00;
      m_byte_last_r  <= 1'b0;
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
      frame_err_r    <= 1'b0;
    end else begin
      req_ready_r    <= (state_s == IDLE);
      m_start_r      <= (state_s == START);
      m_byte_valid_r <= (state_s == SEND);
      m_byte_r       <= (state_s == SEND) ? frame_byte(frame_s, idx_s) : 8'h00;
      m_byte_last_r  <= (state_s == SEND) && (idx_s == LAST_IDX);
      busy_r         <= (state_s != IDLE);
      frame_done_r   <= (state_s == DONE);
      frame_err_r    <= (state_s == ERR);
    end
  end

  assign req_ready    = req_ready_r;
  assign m_start      = m_start_r;
  assign m_addr       = SLAVE_ADDR;
  assign m_byte_valid = m_byte_valid_r;
  assign m_byte       = m_byte_r;
  assign m_byte_last  = m_byte_last_r;
  assign busy         = busy_r;
  assign frame_done   = frame_done_r;
  assign frame_err    = frame_err_r;
  assign retry_cnt    = retry_r;

endmodule

// File: tb/tb_i2c_frame_tx.sv
// Scoreboard bench for i2c_frame_tx: expected bytes, m_start cycles and end pulses are queued
// when a request is accepted or m_done is seen, and one monitor pops and compares them.
module tb_i2c_frame_tx;

  localparam int GAP = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_opcode;
  logic [31:0] req_a, req_b, req_ans;
  logic        m_start;
  logic [6:0]  m_addr;
  logic        m_byte_valid;
  logic [7:0]  m_byte;
  logic        m_byte_last;
  logic        m_byte_ready;
  logic        m_done;
  logic        m_nack;
  logic        busy;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  retry_cnt;

  i2c_frame_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ans      (req_ans),
    .m_start      (m_start),
    .m_addr       (m_addr),
    .m_byte_valid (m_byte_valid),
    .m_byte       (m_byte),
    .m_byte_last  (m_byte_last),
    .m_byte_ready (m_byte_ready),
    .m_done       (m_done),
    .m_nack       (m_nack),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] cur_exp [13];
  logic [8:0] byte_q [$];
  int         start_q [$];
  int         evt_kind_q [$];
  int         evt_cyc_q [$];
  logic       resp_q [$];

  int prem_idx     = -1;
  bit bp_mode      = 1'b0;
  int last_acc_cyc = -100;
  int prem_acc_cyc = -100;
  int m_retry      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic void push_frame();
    for (int i = 0; i < 13; i++) byte_q.push_back({(i == 12), cur_exp[i]});
  endfunction

  task automatic set_exp(input logic [103:0] bytes);
    for (int i = 0; i < 13; i++) cur_exp[i] = bytes[103 - 8*i -: 8];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},    64'(req_ready),    64'd1);
    check({tag, "_busy"},         64'(busy),         64'd0);
    check({tag, "_m_start"},      64'(m_start),      64'd0);
    check({tag, "_m_byte_valid"}, 64'(m_byte_valid), 64'd0);
    check({tag, "_m_byte"},       64'(m_byte),       64'd0);
    check({tag, "_m_byte_last"},  64'(m_byte_last),  64'd0);
    check({tag, "_frame_done"},   64'(frame_done),   64'd0);
    check({tag, "_frame_err"},    64'(frame_err),    64'd0);
    check({tag, "_retry_cnt"},    64'(retry_cnt),    64'd0);
    check({tag, "_m_addr"},       64'(m_addr),       64'h07);
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Ready driver: tied high, or the repeating 1,0,0,1 backpressure pattern.
  initial begin : ready_drv
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    m_byte_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        m_byte_ready = pat[3 - ph];
        ph = (ph + 1) % 4;
      end else begin
        m_byte_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Master model: ends the transaction two cycles after the last byte, or early on request.
  initial begin : responder
    m_done = 1'b0;
    m_nack = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_done = 1'b0;
      m_nack = 1'b0;
      if (cyc == prem_acc_cyc + 1) begin
        m_done = 1'b1;
      end else if (cyc == last_acc_cyc + 2) begin
        m_done = 1'b1;
        if (resp_q.size() > 0) m_nack = resp_q.pop_front();
      end
    end
  end

  initial begin : monitor
    logic       prev_stall;
    logic [8:0] prev_word, got, exp;
    int k;
    prev_stall = 1'b0;
    prev_word  = 9'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        byte_q.delete();
        start_q.delete();
        evt_kind_q.delete();
        evt_cyc_q.delete();
        m_retry = 0;
        prev_stall = 1'b0;
      end else begin
        if (req_valid && req_ready) begin
          m_retry = 0;
          byte_q.delete();
          push_frame();
          start_q.push_back(cyc + 1);
        end
        if (m_done) begin
          if (m_nack || byte_q.size() != 0) begin
            byte_q.delete();
            if (m_retry < 3) begin
              m_retry++;
              push_frame();
              start_q.push_back(cyc + 1 + GAP);
            end else begin
              evt_kind_q.push_back(2);
              evt_cyc_q.push_back(cyc + 1);
            end
          end else begin
            evt_kind_q.push_back(1);
            evt_cyc_q.push_back(cyc + 1);
          end
        end
        got = {m_byte_last, m_byte};
        if (m_byte_valid) begin
          if (prev_stall) check("byte_stable", 64'(got), 64'(prev_word));
          if (m_byte_ready && !m_done) begin
            if (byte_q.size() == 0) begin
              fail_now("byte_unexpected", 64'(got));
            end else begin
              exp = byte_q.pop_front();
              check("frame_byte", 64'(got), 64'(exp));
              k = 12 - byte_q.size();
              if (exp[8]) last_acc_cyc = cyc;
              if (m_retry == 0 && k == prem_idx) prem_acc_cyc = cyc;
            end
          end
          prev_stall = !m_byte_ready;
          prev_word  = got;
        end else begin
          prev_stall = 1'b0;
        end
        if (m_start) begin
          if (start_q.size() == 0) fail_now("m_start_unexpected", 64'(cyc));
          else check("m_start_cycle", 64'(cyc), 64'(start_q.pop_front()));
        end
        if (frame_done || frame_err) begin
          if (evt_kind_q.size() == 0) begin
            fail_now("end_pulse_unexpected", 64'({frame_err, frame_done}));
          end else begin
            check("end_kind", 64'(frame_err ? 2 : 1), 64'(evt_kind_q.pop_front()));
            check("end_cycle", 64'(cyc), 64'(evt_cyc_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic send_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ans);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_ans = ans;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("accept_timeout", 64'(req_ready));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input logic [1:0] exp_retry);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (frame_done || frame_err) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now({tag, "_end_timeout"}, 64'(busy));
    @(negedge clk);
    check({tag, "_req_ready_back"}, 64'(req_ready), 64'd1);
    check({tag, "_busy_clear"},     64'(busy),      64'd0);
    check({tag, "_retry_cnt"},      64'(retry_cnt), 64'(exp_retry));
  endtask

  initial begin : stimulus
    rst_n = 1'b0;
    req_valid = 1'b0; req_opcode = 2'd0; req_a = 32'd0; req_b = 32'd0; req_ans = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal frame, ACK.
    set_exp({8'hFE, 8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00,
             8'h40, 8'h80, 8'h00, 8'h00});
    resp_q.push_back(1'b0);
    send_req(2'b10, 32'h40000000, 32'h40000000, 32'h40800000);
    wait_end("nominal", 2'd0);

    // Backpressure 1,0,0,1.
    bp_mode = 1'b1;
    set_exp({8'hFD, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
             8'hAC, 8'hF1, 8'h35, 8'h68});
    resp_q.push_back(1'b0);
    send_req(2'b01, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568);
    wait_end("backpressure", 2'd0);
    bp_mode = 1'b0;

    // One NACK then ACK.
    set_exp({8'hFC, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04,
             8'h00, 8'h00, 8'h00, 8'h07});
    resp_q.push_back(1'b1);
    resp_q.push_back(1'b0);
    send_req(2'b00, 32'h00000003, 32'h00000004, 32'h00000007);
    wait_end("single_nack", 2'd1);

    // Every attempt NACKed: four starts, then frame_err.
    set_exp({8'hFF, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01,
             8'hDE, 8'hAD, 8'hBE, 8'hEE});
    for (int i = 0; i < 4; i++) resp_q.push_back(1'b1);
    send_req(2'b11, 32'hDEADBEEF, 32'h00000001, 32'hDEADBEEE);
    wait_end("exhaust", 2'd3);

    // Premature m_done after byte 5, plus a conflicting request while busy.
    prem_idx = 5;
    set_exp({8'hFD, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
             8'h33, 8'h33, 8'h33, 8'h33});
    resp_q.push_back(1'b0);
    send_req(2'b01, 32'h11111111, 32'h22222222, 32'h33333333);
    req_valid = 1'b1; req_opcode = 2'b10; req_a = 32'hAAAAAAAA; req_b = 32'h55555555;
    req_ans = 32'hFFFFFFFF;
    repeat (8) @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_end("premature", 2'd1);
    prem_idx = -1;

    // Reset while byte 7 is on the bus.
    set_exp({8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'h09, 8'h0A, 8'h0B, 8'h0C});
    send_req(2'b10, 32'h01020304, 32'h05060708, 32'h090A0B0C);
    repeat (8) @(posedge clk);
    #2;
    check("byte7_on_bus", 64'({m_byte_valid, m_byte}), 64'h107);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    resp_q.push_back(1'b0);
    send_req(2'b10, 32'h01020304, 32'h05060708, 32'h090A0B0C);
    wait_end("after_reset", 2'd0);

    repeat (4) @(posedge clk);
    #1;
    check("byte_q_drained",  64'(byte_q.size()),     64'd0);
    check("start_q_drained", 64'(start_q.size()),    64'd0);
    check("evt_q_drained",   64'(evt_kind_q.size()), 64'd0);
    check("resp_q_drained",  64'(resp_q.size()),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
